reg_scoreboard: RTL and testbench

REG_SCOREBOARD -- requirements
Module: reg_scoreboard

---
 rtl/reg_scoreboard_pkg.sv | 14 +
 rtl/sb_counter.sv | 46 ++++
 rtl/reg_scoreboard.sv | 68 ++++++
 tb/tb_reg_scoreboard.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/reg_scoreboard_pkg.sv
// Shared processor constants and scoreboard helper types.
package reg_scoreboard_pkg;

  localparam int unsigned RegIdxW = 5;
  localparam int unsigned NumRegs = 32;

  typedef logic [RegIdxW-1:0] reg_idx_t;

  // r0 is hardwired to zero, so it is never tracked.
  function automatic logic is_zero_reg(input reg_idx_t r);
    return r == '0;
  endfunction

endpackage

// File: rtl/sb_counter.sv
// Saturating in-flight write counter for one architectural register.
module sb_counter #(
  parameter int unsigned CNT_W = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  input  logic             dec_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o
);

  localparam logic [CNT_W-1:0] CntMax  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CntZero = '0;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: clear wins; simultaneous inc and dec cancel; saturate at both ends.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = CntZero;
    end else if (inc_i && !dec_i) begin
      if (cnt_q != CntMax) cnt_d = cnt_q + 1'b1;
    end else if (dec_i && !inc_i) begin
      if (cnt_q != CntZero) cnt_d = cnt_q - 1'b1;
    end
  end

  // Count register with asynchronous reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= CntZero;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

  // A retire with nothing in flight points at an upstream bookkeeping bug.
  underflow_chk : assert property (@(posedge clk_i) disable iff (rst_i)
      !(dec_i && !inc_i && !clr_i && (cnt_q == CntZero)))
    else $error("sb_counter: write-back retired on a register with no pending write");

endmodule

// File: rtl/reg_scoreboard.sv
// Register scoreboard: tracks in-flight writes per register and stalls decode on hazards.
module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter int unsigned CNT_W = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               issue_valid,
  input  logic [RegIdxW-1:0] dest_reg,
  input  logic               dest_we,
  input  logic [RegIdxW-1:0] rs_reg,
  input  logic               rs_use,
  input  logic [RegIdxW-1:0] rt_reg,
  input  logic               rt_use,
  input  logic               wb_valid,
  input  logic [RegIdxW-1:0] wb_reg,
  input  logic               flush,
  output logic               stall,
  output logic               issue_accept,
  output logic               busy
);

  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  logic [CNT_W-1:0] cnt [NumRegs];
  logic             rs_block, rt_block, dest_full;

  assign cnt[0] = '0;

  for (genvar i = 1; i < NumRegs; i++) begin : g_cnt
    logic inc, dec;
    assign inc = issue_accept && dest_we && (dest_reg == reg_idx_t'(i));
    assign dec = wb_valid && (wb_reg == reg_idx_t'(i));

    sb_counter #(
      .CNT_W(CNT_W)
    ) u_cnt (
      .clk_i(clock),
      .rst_i(reset),
      .inc_i(inc),
      .dec_i(dec),
      .clr_i(flush),
      .cnt_o(cnt[i])
    );
  end

  // Hazard detection; a source whose last pending write retires this cycle is bypassed.
  always_comb begin
    rs_block  = rs_use && !is_zero_reg(rs_reg) && (cnt[rs_reg] != '0) &&
                !(wb_valid && (wb_reg == rs_reg) && (cnt[rs_reg] == CntOne));
    rt_block  = rt_use && !is_zero_reg(rt_reg) && (cnt[rt_reg] != '0) &&
                !(wb_valid && (wb_reg == rt_reg) && (cnt[rt_reg] == CntOne));
    dest_full = dest_we && !is_zero_reg(dest_reg) && (cnt[dest_reg] == CntMax);
    stall        = issue_valid && (rs_block || rt_block || dest_full);
    issue_accept = issue_valid && !stall;
  end

  // Busy reflects only registered counter state.
  always_comb begin
    busy = 1'b0;
    for (int i = 1; i < NumRegs; i++) begin
      busy = busy | (cnt[i] != '0);
    end
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard: directed scenarios then randomized traffic.
module tb_reg_scoreboard;

  localparam int CW   = 2;
  localparam int MAXC = (1 << CW) - 1;

  logic       clock = 1'b0;
  logic       reset;
  logic       issue_valid, dest_we, rs_use, rt_use, wb_valid, flush;
  logic [4:0] dest_reg, rs_reg, rt_reg, wb_reg;
  logic       stall, issue_accept, busy;

  int counts[32];
  int n_cmp  = 0;
  int n_fail = 0;

  reg_scoreboard #(
    .CNT_W(CW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .issue_valid(issue_valid),
    .dest_reg(dest_reg),
    .dest_we(dest_we),
    .rs_reg(rs_reg),
    .rs_use(rs_use),
    .rt_reg(rt_reg),
    .rt_use(rt_use),
    .wb_valid(wb_valid),
    .wb_reg(wb_reg),
    .flush(flush),
    .stall(stall),
    .issue_accept(issue_accept),
    .busy(busy)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) counts[i] = 0;
  endtask

  function automatic bit model_busy();
    for (int i = 0; i < 32; i++) if (counts[i] > 0) return 1'b1;
    return 1'b0;
  endfunction

  // A source waits if it has pending writes, unless its single pending write retires now.
  function automatic bit src_wait(input int r, input bit used);
    if (!used || r == 0 || counts[r] == 0) return 1'b0;
    if (wb_valid && int'(wb_reg) == r && counts[r] == 1) return 1'b0;
    return 1'b1;
  endfunction

  task automatic set_in(input bit iv, input int d, input bit we, input int rs, input bit ru,
                        input int rt, input bit tu, input bit wv, input int wr, input bit fl);
    issue_valid = iv;
    dest_reg    = 5'(d);
    dest_we     = we;
    rs_reg      = 5'(rs);
    rs_use      = ru;
    rt_reg      = 5'(rt);
    rt_use      = tu;
    wb_valid    = wv;
    wb_reg      = 5'(wr);
    flush       = fl;
  endtask

  task automatic idle();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Called at a negedge with inputs set: check outputs, clock once, advance the model.
  task automatic step(input string tag);
    bit es, ea, eb;
    #1;
    es = issue_valid && (src_wait(int'(rs_reg), rs_use) || src_wait(int'(rt_reg), rt_use) ||
         (dest_we && dest_reg != 0 && counts[dest_reg] == MAXC));
    ea = issue_valid && !es;
    eb = model_busy();
    check({tag, ".stall"}, stall, es);
    check({tag, ".accept"}, issue_accept, ea);
    check({tag, ".busy"}, busy, eb);
    @(posedge clock);
    if (flush) begin
      model_clear();
    end else begin
      if (ea && dest_we && dest_reg != 0) counts[dest_reg] = counts[dest_reg] + 1;
      if (wb_valid && wb_reg != 0 && counts[wb_reg] > 0) counts[wb_reg] = counts[wb_reg] - 1;
    end
    @(negedge clock);
  endtask

  initial begin
    int pend[$];
    int d, rs, rt;
    bit wv;
    int wr;

    model_clear();
    idle();
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    #1;
    check("rst.stall", stall, 1'b0);
    check("rst.accept", issue_accept, 1'b0);
    check("rst.busy", busy, 1'b0);
    reset = 1'b0;
    @(negedge clock);

    // Read-after-write hazard released by write-back bypass.
    set_in(1, 5, 1, 0, 0, 0, 0, 0, 0, 0); step("raw.issue5");
    set_in(1, 0, 0, 5, 1, 0, 0, 0, 0, 0); step("raw.read5a");
    check("raw.busy_after", busy, 1'b1);
    step("raw.read5b");
    set_in(1, 0, 0, 5, 1, 0, 0, 1, 5, 0);
    #1;
    check("raw.bypass_stall", stall, 1'b0);
    check("raw.bypass_accept", issue_accept, 1'b1);
    step("raw.bypass");

    // r0 is never pending.
    set_in(1, 0, 1, 0, 0, 0, 0, 0, 0, 0); step("r0.issue");
    set_in(1, 0, 0, 0, 1, 0, 1, 0, 0, 0); step("r0.read");
    check("r0.busy", busy, 1'b0);

    // Counter saturation at max outstanding writes.
    for (int i = 0; i < 3; i++) begin
      set_in(1, 7, 1, 0, 0, 0, 0, 0, 0, 0); step("sat.issue7");
    end
    #1;
    check("sat.fourth_stall", stall, 1'b1);
    step("sat.fourth");
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 7, 0); step("sat.wb7");
    set_in(1, 7, 1, 0, 0, 0, 0, 0, 0, 0); step("sat.reissue7");
    for (int i = 0; i < 3; i++) begin
      set_in(0, 0, 0, 0, 0, 0, 0, 1, 7, 0); step("sat.drain7");
    end
    idle();
    #1;
    check("sat.empty", busy, 1'b0);
    step("sat.idle");

    // Same-cycle issue and retire to one register leaves the count unchanged.
    set_in(1, 9, 1, 0, 0, 0, 0, 0, 0, 0); step("same.issue9");
    set_in(1, 9, 1, 0, 0, 0, 0, 1, 9, 0); step("same.both9");
    set_in(1, 0, 0, 0, 0, 9, 1, 0, 0, 0);
    #1;
    check("same.still_pending", stall, 1'b1);
    step("same.read9");
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 9, 0); step("same.wb9");

    // Flush discards pending writes; stall in the flush cycle uses current counts.
    set_in(1, 3, 1, 0, 0, 0, 0, 0, 0, 0); step("fl.issue3");
    set_in(1, 4, 1, 0, 0, 0, 0, 0, 0, 0); step("fl.issue4");
    set_in(1, 5, 1, 0, 0, 0, 0, 0, 0, 0); step("fl.issue5");
    set_in(1, 6, 1, 3, 1, 0, 0, 0, 0, 1); step("fl.flush");
    set_in(1, 0, 0, 3, 1, 4, 1, 0, 0, 0); step("fl.read34");
    set_in(1, 0, 0, 5, 1, 0, 0, 0, 0, 0); step("fl.read5");

    // Asynchronous reset in the middle of a cycle.
    set_in(1, 2, 1, 0, 0, 0, 0, 0, 0, 0); step("rm.issue2");
    set_in(1, 8, 1, 0, 0, 0, 0, 0, 0, 0); step("rm.issue8");
    idle();
    #2;
    reset = 1'b1;
    #1;
    model_clear();
    check("rm.busy_now", busy, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    set_in(1, 0, 0, 2, 1, 8, 1, 0, 0, 0); step("rm.read2");

    // Randomized traffic over a small register window to provoke collisions.
    for (int n = 0; n < 300; n++) begin
      pend.delete();
      for (int r = 1; r < 8; r++) if (counts[r] > 0) pend.push_back(r);
      d  = int'($urandom_range(0, 7));
      rs = int'($urandom_range(0, 7));
      rt = int'($urandom_range(0, 7));
      wv = (pend.size() > 0) && ($urandom_range(0, 1) == 1);
      wr = wv ? pend[$urandom_range(0, pend.size() - 1)] : 0;
      set_in($urandom_range(0, 3) != 0, d, $urandom_range(0, 3) != 0, rs,
             $urandom_range(0, 1) == 1, rt, $urandom_range(0, 1) == 1, wv, wr,
             $urandom_range(0, 24) == 0);
      step("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
